// File: rtl/tx_core_self_contained_pkg.sv
// Shared types, line-level constants and the parity helper for the serial transmitter.
package tx_core_self_contained_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_GUARD  = 3'd6
  } tx_state_e;

  localparam logic LVL_START = 1'b0;
  localparam logic LVL_STOP  = 1'b1;

  // Parity bit that gives data+parity an even (odd=0) or odd (odd=1) count of ones.
  function automatic logic parityBit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/tx_core_self_contained_counter.sv
// Tick prescaler plus per-bit tick counter; wrap_o marks the last tick of a bit.
module Counter #(
  parameter int WIDTH      = 13,
  parameter int WIDTH_INIT = 1
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  clear_i,
  input  logic [WIDTH_INIT-1:0] divider_i,
  input  logic [WIDTH-1:0]      terminal_i,
  output logic                  tick_o,
  output logic                  wrap_o,
  output logic [WIDTH-1:0]      count_o
);

  logic [WIDTH_INIT-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]      count_q, count_d;

  always_comb begin
    tick_o  = !clear_i && (presc_q == divider_i);
    wrap_o  = tick_o && (count_q == terminal_i);
    presc_d = presc_q + 1'b1;
    count_d = count_q;
    if (tick_o) begin
      presc_d = '0;
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
    if (clear_i) begin
      presc_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tx_core_self_contained.sv
// Byte-wide asynchronous serial transmitter with parity and one/two stop bits.
// Define TX_ERROR_SIGNAL_EN to add receiver error-signal detection and retransmission.
module tx_core_self_contained
  import tx_core_self_contained_pkg::*;
#(
  parameter int   DIVIDER_WIDTH       = 1,
  parameter int   CLOCK_PER_BIT_WIDTH = 13,
  parameter logic START_BIT           = LVL_START,
  parameter logic STOP_BIT1           = LVL_STOP,
  parameter logic STOP_BIT2           = LVL_STOP,
  parameter int   MAX_RETRIES         = 4
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic [7:0]                     dataIn,
  input  logic                           loadDataIn,
  input  logic [DIVIDER_WIDTH-1:0]       clkPerCycle,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  input  logic                           stopBit2,
  input  logic                           oddParity,
  input  logic                           msbFirst,
  input  logic                           ackFlags,
  input  logic                           serialIn,
  output logic                           serialOut,
  output logic                           full,
  output logic                           run,
  output logic                           endOfTx,
  output logic                           overrunErrorFlag,
  output logic                           errorSignalFlag,
  output logic                           frameErrorFlag
);

  localparam int CPBW = CLOCK_PER_BIT_WIDTH;
  localparam int RW   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  tx_state_e          state_q, state_d;
  logic               full_q, full_d;
  logic [2:0]         idx_q, idx_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic               errDet_q, errDet_d;
  logic               ovr_q, ovr_d, errSig_q, errSig_d, frmErr_q, frmErr_d;

  logic [7:0]               hold_q, data_q;
  logic [DIVIDER_WIDTH-1:0] div_q;
  logic [CPBW-1:0]          cpb_q;
  logic                     stop2_q, odd_q, msb_q;

  logic            tick, bitEnd;
  logic [CPBW-1:0] bitCount;
  logic            loadOk, startFrame, frameEnd, sampleEn, errHit, errAny;

  Counter #(
    .WIDTH      (CPBW),
    .WIDTH_INIT (DIVIDER_WIDTH)
  ) u_counter (
    .clk        (clk),
    .nReset     (nReset),
    .clear_i    (state_q == S_IDLE),
    .divider_i  (div_q),
    .terminal_i (cpb_q),
    .tick_o     (tick),
    .wrap_o     (bitEnd),
    .count_o    (bitCount)
  );

`ifdef TX_ERROR_SIGNAL_EN
  logic [CPBW:0] halfSum;
  assign halfSum  = {1'b0, cpb_q} + 1'b1;
  assign sampleEn = (state_q == S_STOP1) && tick && (bitCount == halfSum[CPBW:1]);
`else
  logic unusedCount;
  assign unusedCount = tick ^ (^bitCount);
  assign sampleEn    = 1'b0;
`endif

  assign loadOk = loadDataIn && !full_q;
  assign errHit = sampleEn && (serialIn == 1'b0);
  assign errAny = errDet_q || errHit;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      full_q   <= 1'b0;
      idx_q    <= '0;
      retry_q  <= '0;
      errDet_q <= 1'b0;
      ovr_q    <= 1'b0;
      errSig_q <= 1'b0;
      frmErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      errDet_q <= errDet_d;
      ovr_q    <= ovr_d;
      errSig_q <= errSig_d;
      frmErr_q <= frmErr_d;
    end
  end

  // Payload and per-frame configuration carry no reset; full_q gates their use.
  always_ff @(posedge clk) begin
    if (loadOk) hold_q <= dataIn;
    if (startFrame) begin
      data_q  <= hold_q;
      div_q   <= clkPerCycle;
      cpb_q   <= clocksPerBit;
      stop2_q <= stopBit2;
      odd_q   <= oddParity;
      msb_q   <= msbFirst;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    errDet_d   = errDet_q || errHit;
    startFrame = 1'b0;
    frameEnd   = 1'b0;
    case (state_q)
      S_IDLE:   if (full_q) startFrame = 1'b1;
      S_START:  if (bitEnd) begin state_d = S_DATA; idx_d = '0; end
      S_DATA:   if (bitEnd) begin
                  idx_d = idx_q + 3'd1;
                  if (idx_q == 3'd7) state_d = S_PARITY;
                end
      S_PARITY: if (bitEnd) begin state_d = S_STOP1; errDet_d = 1'b0; end
      S_STOP1:  if (bitEnd) begin
                  if (errAny && (retry_q != RW'(MAX_RETRIES))) begin
                    state_d = S_GUARD;
                    idx_d   = '0;
                    retry_d = retry_q + 1'b1;
                  end else if (errAny || !stop2_q) frameEnd = 1'b1;
                  else state_d = S_STOP2;
                end
      S_STOP2:  if (bitEnd) frameEnd = 1'b1;
`ifdef TX_ERROR_SIGNAL_EN
      // Two idle bit times, then resend the byte already in data_q.
      S_GUARD:  if (bitEnd) begin
                  if (idx_q == 3'd1) state_d = S_START;
                  else idx_d = idx_q + 3'd1;
                end
`endif
      default:  state_d = S_IDLE;
    endcase
    if (frameEnd) begin
      if (full_q) startFrame = 1'b1;
      else state_d = S_IDLE;
    end
    if (startFrame) begin
      state_d = S_START;
      retry_d = '0;
    end
  end

  always_comb begin
    full_d = full_q;
    if (startFrame) full_d = 1'b0;
    if (loadOk) full_d = 1'b1;
    ovr_d    = ackFlags ? 1'b0 : ovr_q;
    errSig_d = ackFlags ? 1'b0 : errSig_q;
    frmErr_d = ackFlags ? 1'b0 : frmErr_q;
    if (loadDataIn && full_q) ovr_d = 1'b1;
    if (errHit) errSig_d = 1'b1;
    if (frameEnd && errAny) frmErr_d = 1'b1;
  end

  always_comb begin
    serialOut = STOP_BIT1;
    case (state_q)
      S_START:  serialOut = START_BIT;
      S_DATA:   serialOut = msb_q ? data_q[~idx_q] : data_q[idx_q];
      S_PARITY: serialOut = parityBit(data_q, odd_q);
      S_STOP2:  serialOut = STOP_BIT2;
      default:  serialOut = STOP_BIT1;
    endcase
    full             = full_q;
    run              = (state_q != S_IDLE);
    endOfTx          = frameEnd;
    overrunErrorFlag = ovr_q;
    errorSignalFlag  = errSig_q;
    frameErrorFlag   = frmErr_q;
  end

endmodule

// File: tb/tb_tx_core_self_contained.sv
// Directed bench: expected frames go into a queue, an independent line monitor checks them.
module tb_tx_core_self_contained;

  logic        clk = 1'b0;
  logic        nReset;
  logic [7:0]  dataIn;
  logic        loadDataIn;
  logic [0:0]  clkPerCycle;
  logic [12:0] clocksPerBit;
  logic        stopBit2, oddParity, msbFirst, ackFlags, serialIn;
  logic        serialOut, full, run, endOfTx;
  logic        overrunErrorFlag, errorSignalFlag, frameErrorFlag;

  tx_core_self_contained dut (
    .clk              (clk),
    .nReset           (nReset),
    .dataIn           (dataIn),
    .loadDataIn       (loadDataIn),
    .clkPerCycle      (clkPerCycle),
    .clocksPerBit     (clocksPerBit),
    .stopBit2         (stopBit2),
    .oddParity        (oddParity),
    .msbFirst         (msbFirst),
    .ackFlags         (ackFlags),
    .serialIn         (serialIn),
    .serialOut        (serialOut),
    .full             (full),
    .run              (run),
    .endOfTx          (endOfTx),
    .overrunErrorFlag (overrunErrorFlag),
    .errorSignalFlag  (errorSignalFlag),
    .frameErrorFlag   (frameErrorFlag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:11] bits;   // bits[0] is the first bit on the line
    int          n;
    int          cpc;    // clk cycles per bit
    logic        eot;
    logic        abort;
    logic        b2b;
  } frame_t;

  frame_t expQ[$];
  int     errors = 0;
  int     checks = 0;
  int     cycle = 0;
  int     strayEot = 0;
  int     lastEndCycle = -100;
  int     frameNo = 0;
  bit     monBusy = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [0:11] bits, input int n, input int cpc,
                                input logic eot, input logic abort, input logic b2b);
    frame_t f;
    f.bits = bits; f.n = n; f.cpc = cpc; f.eot = eot; f.abort = abort; f.b2b = b2b;
    return f;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic div, input int cpb, input logic odd, input logic msb, input logic s2);
    clkPerCycle = div; clocksPerBit = 13'(cpb); oddParity = odd; msbFirst = msb; stopBit2 = s2;
  endtask

  task automatic load(input logic [7:0] d);
    dataIn = d; loadDataIn = 1'b1;
    cyc(1);
    loadDataIn = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while ((expQ.size() != 0 || monBusy || run) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < bound), 1);
    sync();
  endtask

  // Line monitor: each falling edge to the start level begins the next expected frame.
  initial begin : monitor
    frame_t f;
    bit     ok, aborted;
    int     startCyc, w;
    forever begin
      @(negedge clk);
      if (nReset && endOfTx) strayEot++;
      if (nReset && serialOut === 1'b0) begin
        monBusy  = 1'b1;
        startCyc = cycle;
        if (expQ.size() == 0) begin
          check("unexpected_frame", 1, 0);
          w = 0;
          while (run && w < 2000) begin @(negedge clk); w++; end
        end else begin
          f = expQ.pop_front();
          if (f.b2b) check($sformatf("no_idle_gap_f%0d", frameNo), startCyc - lastEndCycle, 1);
          aborted = 1'b0;
          for (int b = 0; b < f.n && !aborted; b++) begin
            ok = 1'b1;
            for (int c = 0; c < f.cpc; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (!nReset) begin aborted = 1'b1; break; end
              if (serialOut !== f.bits[b]) ok = 1'b0;
              if (b == f.n - 1 && c == f.cpc - 1)
                check($sformatf("eot_f%0d", frameNo), endOfTx, f.eot);
              else if (endOfTx) ok = 1'b0;
            end
            if (!aborted) check($sformatf("bit%0d_exp%0b_f%0d", b, f.bits[b], frameNo), ok, 1);
          end
          check($sformatf("abort_f%0d", frameNo), aborted, f.abort);
          frameNo++;
        end
        lastEndCycle = cycle;
        monBusy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    nReset = 1'b0; loadDataIn = 1'b0; dataIn = 8'h00; ackFlags = 1'b0; serialIn = 1'b1;
    set_cfg(1'b0, 3, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_serialOut", serialOut, 1);
    check("rst_full", full, 0);
    check("rst_run", run, 0);
    check("rst_endOfTx", endOfTx, 0);
    check("rst_flags", {overrunErrorFlag, errorSignalFlag, frameErrorFlag}, 0);
    sync();
    nReset = 1'b1;
    cyc(2);

    // A5, LSB first, even parity, one stop bit, 4 cycles per bit
    expQ.push_back(mk({11'b01010010101, 1'b1}, 11, 4, 1'b1, 1'b0, 1'b0));
    load(8'hA5);
    @(negedge clk);
    check("lat_full_set", full, 1);
    check("lat_line_idle", serialOut, 1);
    @(negedge clk);
    check("lat_start_bit", serialOut, 0);
    check("lat_full_clr", full, 0);
    check("lat_run", run, 1);
    sync();
    set_cfg(1'b1, 0, 1'b1, 1'b1, 1'b1);   // must not disturb the frame in flight
    wait_idle("s1_done", 300);
    check("s1_run_low", run, 0);

    // 3B, MSB first, odd parity, two stop bits, 6 cycles per bit via the divider
    set_cfg(1'b1, 2, 1'b1, 1'b1, 1'b1);
    expQ.push_back(mk(12'b000111011011, 12, 6, 1'b1, 1'b0, 1'b0));
    load(8'h3B);
    wait_idle("s2_done", 400);

    // Overrun, flag priority over ack, and back-to-back frames
    set_cfg(1'b0, 3, 1'b0, 1'b0, 1'b0);
    expQ.push_back(mk({11'b01000000011, 1'b1}, 11, 4, 1'b1, 1'b0, 1'b0));
    expQ.push_back(mk({11'b00000000111, 1'b1}, 11, 4, 1'b1, 1'b0, 1'b1));
    load(8'h01);
    cyc(1);
    load(8'h80);
    @(negedge clk);
    check("s3_full_second", full, 1);
    check("s3_no_overrun_yet", overrunErrorFlag, 0);
    sync();
    load(8'hFF);
    @(negedge clk);
    check("s3_overrun_set", overrunErrorFlag, 1);
    sync();
    ackFlags = 1'b1; dataIn = 8'hFF; loadDataIn = 1'b1;
    cyc(1);
    ackFlags = 1'b0; loadDataIn = 1'b0;
    @(negedge clk);
    check("s3_set_beats_ack", overrunErrorFlag, 1);
    sync();
    ackFlags = 1'b1;
    cyc(1);
    ackFlags = 1'b0;
    @(negedge clk);
    check("s3_ack_clears", overrunErrorFlag, 0);
    sync();
    wait_idle("s3_done", 400);

    // Receiver holds the line low through every stop bit
    serialIn = 1'b0;
`ifdef TX_ERROR_SIGNAL_EN
    for (int i = 0; i < 5; i++)
      expQ.push_back(mk({11'b01010010101, 1'b1}, 11, 4, (i == 4), 1'b0, 1'b0));
    load(8'hA5);
    wait_idle("s4_done", 1000);
    check("s4_errsig", errorSignalFlag, 1);
    check("s4_frameerr", frameErrorFlag, 1);
    check("s4_full", full, 0);
    ackFlags = 1'b1;
    cyc(1);
    ackFlags = 1'b0;
    @(negedge clk);
    check("s4_ack_clears", {errorSignalFlag, frameErrorFlag}, 0);
    sync();
`else
    expQ.push_back(mk({11'b01010010101, 1'b1}, 11, 4, 1'b1, 1'b0, 1'b0));
    load(8'hA5);
    wait_idle("s4_done", 400);
    check("s4_errsig_tied", errorSignalFlag, 0);
    check("s4_frameerr_tied", frameErrorFlag, 0);
`endif
    serialIn = 1'b1;

    // Reset in the middle of the DATA state with a byte waiting in the holding register
    expQ.push_back(mk({11'b00000111101, 1'b1}, 11, 4, 1'b0, 1'b1, 1'b0));
    load(8'hF0);
    cyc(1);
    load(8'h55);
    cyc(6);
    nReset = 1'b0;
    @(negedge clk);
    check("s5_line_high", serialOut, 1);
    check("s5_full_dropped", full, 0);
    check("s5_run_low", run, 0);
    sync();
    cyc(1);
    nReset = 1'b1;
    cyc(10);
    check("s5_no_restart", run, 0);
    expQ.push_back(mk({11'b01111000001, 1'b1}, 11, 4, 1'b1, 1'b0, 1'b0));
    load(8'h0F);
    wait_idle("s5_done", 300);

    check("stray_eot", strayEot, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_core_self_contained.md
TX_CORE_SELF_CONTAINED -- requirements
Module: tx_core_self_contained

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and nReset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- DIVIDER_WIDTH, 1, width of clkPerCycle.
- CLOCK_PER_BIT_WIDTH, 13, width of clocksPerBit.
- START_BIT, 1'b0, start bit level.
- STOP_BIT1, 1'b1, first stop and idle level.
- STOP_BIT2, 1'b1, second stop level.
- MAX_RETRIES, 4, maximum retransmissions after an error signal.
REQ-003 The block SHALL have these ports (name direction width meaning):
- clk in 1 clock.
- nReset in 1 async active-low reset.
- dataIn in 8 byte to send.
- loadDataIn in 1 one-cycle load strobe.
- clkPerCycle in DIVIDER_WIDTH tick divider.
- clocksPerBit in CLOCK_PER_BIT_WIDTH ticks per bit minus 1.
- stopBit2 in 1 selects 2 stop bits.
- oddParity in 1 selects odd parity.
- msbFirst in 1 selects b7 first.
- ackFlags in 1 clears error flags.
- serialIn in 1 line monitor.
- serialOut out 1 line drive.
- full out 1 holding register occupied.
- run out 1 frame in progress.
- endOfTx out 1 one-cycle pulse at the end of the frame.
- overrunErrorFlag out 1 load was rejected.
- errorSignalFlag out 1 receiver signalled an error.
- frameErrorFlag out 1 retries were exhausted.

Function
REQ-004 One tick SHALL occur every clkPerCycle+1 clk cycles, and each bit SHALL last clocksPerBit+1 ticks.
REQ-005 The frame SHALL be sent in this order: start, 8 data bits (LSB first unless msbFirst=1), parity, then 1 stop bit, or 2 stop bits if stopBit2=1.
REQ-006 The parity bit SHALL make data+parity contain an even number of ones, or an odd number of ones when oddParity=1.
REQ-007 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2 and GUARD, with transitions at the bit-end tick.
- STOP2 is skipped when stopBit2=0.
- GUARD is used only under REQ-017.
REQ-008 Load handling:
- loadDataIn with full=0 SHALL capture dataIn into the holding register and set full the next cycle.
- loadDataIn with full=1 SHALL be ignored and SHALL set overrunErrorFlag.
REQ-009 In IDLE with full=1, the holding register SHALL transfer to the shifter and clear full, and serialOut SHALL equal START_BIT on the following cycle. Latency from the load strobe to the start bit, when idle, SHALL be 2 cycles.
REQ-010 If full=1 at the end of the last stop bit, the next start bit SHALL follow immediately, with no idle cycle.
REQ-011 run SHALL be 1 from the START state until endOfTx, inclusive.
REQ-012 endOfTx SHALL pulse during the last cycle of the last stop bit of a frame that is not retried.
REQ-013 ackFlags SHALL clear all three flags; a flag-setting event in the same cycle as ackFlags SHALL take priority.
REQ-014 Parameter and configuration inputs SHALL be sampled at the start of each frame and held constant for that frame.

Reset
REQ-015 While nReset=0, the outputs SHALL be:
- serialOut=STOP_BIT1.
- full, run, endOfTx and all flags = 0.
- FSM in IDLE, retry count 0.
REQ-016 Reset asserted mid-frame SHALL abort the frame immediately, drop the holding register contents, and restart in IDLE.

Configuration
REQ-017 With TX_ERROR_SIGNAL_EN defined, the block SHALL behave as follows:
- serialIn is sampled at tick (clocksPerBit+1)/2 of STOP1.
- If serialIn=0 there, errorSignalFlag is set, endOfTx is suppressed, and the FSM enters GUARD for 2 bit times.
- From GUARD the same byte is retransmitted.
- After MAX_RETRIES failed retransmissions, frameErrorFlag is set, endOfTx pulses, and the byte is dropped.
REQ-018 Without TX_ERROR_SIGNAL_EN, the block SHALL behave as follows:
- serialIn is ignored.
- errorSignalFlag and frameErrorFlag are tied to 0.
- GUARD is absent.

Structure
REQ-019 A shared package SHALL hold the FSM state type, the convention bit constants, and the parity helper function.
REQ-020 The tick and bit-time counter SHALL be the existing Counter sub-module (WIDTH=CLOCK_PER_BIT_WIDTH, WIDTH_INIT=1), instantiated once.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Byte 8'hA5 with clkPerCycle=0, clocksPerBit=3, oddParity=0, msbFirst=0, stopBit2=0 -> serialOut is 0,1,0,1,0,0,1,0,1,0,1, with 4 cycles per bit and endOfTx at cycle 44 after the start bit.
- Byte 8'h3B with msbFirst=1, oddParity=1, stopBit2=1 -> data sent 0,0,1,1,1,0,1,1; parity=0; 2 stop bits.
- Load during the start bit of byte A, then a second load -> the second load is rejected and overrunErrorFlag=1; the next frame starts with no idle gap.
- TX_ERROR_SIGNAL_EN defined, serialIn forced low mid-STOP1 on every frame -> 4 retransmissions, then frameErrorFlag=1 and a single endOfTx pulse.
- nReset pulsed during the DATA state -> serialOut=1 at once, full=0, and a subsequent load transmits normally.
